// File: rtl/lock_pkg.sv
// Shared types and constants for the lock sweep / key-search controller.
package lock_pkg;

  // Widths of the c17 benchmark with a 3-bit key
  localparam int C17_N_IN  = 5;
  localparam int C17_N_OUT = 2;
  localparam int C17_N_KEY = 3;

  localparam logic MODE_VERIFY = 1'b0;
  localparam logic MODE_SEARCH = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/lock_settle_cnt.sv
// Loadable down-counter: after load, expire rises on the SETTLE_CYC-th enabled cycle.
module lock_settle_cnt #(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load on entry to a settle window, count down while enabled, park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = LOAD_VAL;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/lock_sweep_ctrl.sv
// Exhaustive pattern sweep with locked-vs-oracle compare; verifies one key or
// searches keys in ascending order for the first zero-mismatch key.
module lock_sweep_ctrl
  import lock_pkg::*;
#(
  parameter int N_IN       = C17_N_IN,
  parameter int N_OUT      = C17_N_OUT,
  parameter int N_KEY      = C17_N_KEY,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [N_KEY-1:0] key_in,
  input  logic [N_OUT-1:0] dut_out,
  input  logic [N_OUT-1:0] ref_out,
  output logic [N_IN-1:0]  pat,
  output logic [N_KEY-1:0] key,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    mismatch_cnt,
  output logic             key_found,
  output logic [N_KEY-1:0] found_key
);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [N_IN-1:0]    pat_q, pat_d;
  logic [N_KEY-1:0]   key_q, key_d;
  logic [N_IN:0]      mcnt_q, mcnt_d;
  logic               found_q, found_d;
  logic [N_KEY-1:0]   fkey_q, fkey_d;
  logic               settle_load, settle_exp;
  logic               mis, pat_end;
  logic [N_IN:0]      mcnt_inc;

  lock_settle_cnt #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (settle_load),
    .en     (state_q == SETTLE),
    .expire (settle_exp)
  );

  // Compare result for the pattern currently held on the DUT/oracle
  always_comb begin
    mis      = (dut_out != ref_out);
    mcnt_inc = mcnt_q + {{N_IN{1'b0}}, mis};
    // Search mode gives up on a key at its first mismatching pattern
    pat_end  = (&pat_q) || ((mode_q == MODE_SEARCH) && mis);
  end

  // Sweep sequencing and result bookkeeping
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pat_d       = pat_q;
    key_d       = key_q;
    mcnt_d      = mcnt_q;
    found_d     = found_q;
    fkey_d      = fkey_q;
    settle_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          key_d       = (mode == MODE_SEARCH) ? '0 : key_in;
          pat_d       = '0;
          mcnt_d      = '0;
          found_d     = 1'b0;
          fkey_d      = '0;
          settle_load = 1'b1;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_exp) state_d = COMPARE;
      end
      COMPARE: begin
        mcnt_d = mcnt_inc;
        if (!pat_end) begin
          pat_d       = pat_q + N_IN'(1);
          settle_load = 1'b1;
          state_d     = SETTLE;
        end else if (mode_q == MODE_VERIFY) begin
          state_d = DONE;
        end else if (mcnt_inc == '0) begin
          found_d = 1'b1;
          fkey_d  = key_q;
          state_d = DONE;
        end else if (&key_q) begin
          state_d = DONE;
        end else begin
          key_d       = key_q + N_KEY'(1);
          pat_d       = '0;
          mcnt_d      = '0;
          settle_load = 1'b1;
          state_d     = SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; results persist in IDLE until the next start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_VERIFY;
      pat_q   <= '0;
      key_q   <= '0;
      mcnt_q  <= '0;
      found_q <= 1'b0;
      fkey_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      key_q   <= key_d;
      mcnt_q  <= mcnt_d;
      found_q <= found_d;
      fkey_q  <= fkey_d;
    end
  end

  assign pat          = pat_q;
  assign key          = key_q;
  assign busy         = (state_q == SETTLE) || (state_q == COMPARE);
  assign done         = (state_q == DONE);
  assign mismatch_cnt = mcnt_q;
  assign key_found    = found_q;
  assign found_key    = fkey_q;

endmodule

// File: tb/tb_lock_sweep_ctrl.sv
// Bench for lock_sweep_ctrl: c17 with three XOR key gates as the locked DUT,
// plain c17 (or an always-wrong oracle) as reference, per-cycle model compare.
module tb_lock_sweep_ctrl;

  localparam int S = 1;

  logic       clk = 1'b0;
  logic       rst_n, start, mode;
  logic [2:0] key_in;
  logic [1:0] dut_out, ref_out;
  logic [4:0] pat;
  logic [2:0] key;
  logic       busy, done, key_found;
  logic [5:0] mismatch_cnt;
  logic [2:0] found_key;

  logic [2:0] tgt = 3'b111;   // correct key of the locked netlist
  logic       unsolv = 1'b0;  // oracle returns ~dut_out

  int n_vec = 0, n_fail = 0;
  int cyc = 0;

  lock_sweep_ctrl #(.N_IN(5), .N_OUT(2), .N_KEY(3), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in),
    .dut_out(dut_out), .ref_out(ref_out), .pat(pat), .key(key), .busy(busy),
    .done(done), .mismatch_cnt(mismatch_cnt), .key_found(key_found),
    .found_key(found_key)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // c17 with an inversion mask on wires n10, n16, n19
  function automatic logic [1:0] c17(input logic [4:0] p, input logic [2:0] inv);
    logic n10, n11, n16, n19, n22, n23;
    n10 = ~(p[0] & p[2]) ^ inv[0];
    n11 = ~(p[2] & p[3]);
    n16 = ~(p[1] & n11) ^ inv[1];
    n19 = ~(n11 & p[4]) ^ inv[2];
    n22 = ~(n10 & n16);
    n23 = ~(n16 & n19);
    return {n23, n22};
  endfunction

  function automatic logic [1:0] lock_fn(input logic [4:0] p, input logic [2:0] k);
    return c17(p, k ^ tgt);
  endfunction

  function automatic logic [1:0] ref_fn(input logic [4:0] p, input logic [2:0] k);
    return unsolv ? ~lock_fn(p, k) : c17(p, 3'b000);
  endfunction

  assign dut_out = lock_fn(pat, key);
  assign ref_out = ref_fn(pat, key);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the sequence of (pattern, key, count-so-far) steps a sweep visits
  logic [4:0] st_pat[$];
  logic [2:0] st_key[$];
  logic [5:0] st_mc[$];
  logic [5:0] exp_mc;
  logic       exp_found;
  logic [2:0] exp_fkey;
  int         total;

  task automatic build_model(input logic m, input logic [2:0] k);
    int mc;
    bool_loop: begin end
    st_pat.delete(); st_key.delete(); st_mc.delete();
    exp_found = 1'b0; exp_fkey = 3'b000; mc = 0;
    if (!m) begin
      for (int p = 0; p < 32; p++) begin
        st_pat.push_back(5'(p)); st_key.push_back(k); st_mc.push_back(6'(mc));
        if (lock_fn(5'(p), k) != ref_fn(5'(p), k)) mc++;
      end
    end else begin
      for (int kk = 0; kk < 8 && !exp_found; kk++) begin
        mc = 0;
        for (int p = 0; p < 32 && mc == 0; p++) begin
          st_pat.push_back(5'(p)); st_key.push_back(3'(kk)); st_mc.push_back(6'd0);
          if (lock_fn(5'(p), 3'(kk)) != ref_fn(5'(p), 3'(kk))) mc = 1;
        end
        if (mc == 0) begin exp_found = 1'b1; exp_fkey = 3'(kk); end
      end
    end
    exp_mc = 6'(mc);
    total  = st_pat.size() * (S + 1);
  endtask

  // Per-cycle compare against the model, relative to the accepting edge t0
  bit active = 1'b0;
  int t0 = 0;
  always @(negedge clk) begin
    int o, idx;
    if (active) begin
      o = cyc - t0;
      if (o >= 1 && o <= total) begin
        idx = (o - 1) / (S + 1);
        chk("busy", busy, 1); chk("done_early", done, 0);
        chk("pat", pat, st_pat[idx]); chk("key", key, st_key[idx]);
        chk("mcnt_run", mismatch_cnt, st_mc[idx]);
        chk("found_run", key_found, 0); chk("fkey_run", found_key, 0);
      end else if (o >= total + 1) begin
        chk("busy_idle", busy, 0);
        chk(o == total + 1 ? "done_pulse" : "done_extra", done, o == total + 1);
        chk("pat_final", pat, st_pat[st_pat.size()-1]);
        chk("key_final", key, st_key[st_key.size()-1]);
        chk("mcnt_final", mismatch_cnt, exp_mc);
        chk("key_found", key_found, exp_found);
        chk("found_key", found_key, exp_fkey);
      end
    end
  end

  // One sweep; optionally scrambles mode/key_in and pulses start while busy and in DONE
  task automatic run_sweep(input logic m, input logic [2:0] k, input bit jiggle);
    active = 1'b0;
    build_model(m, k);
    @(negedge clk);
    start = 1'b1; mode = m; key_in = k; t0 = cyc; active = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - t0 <= total + 2) begin
      if (jiggle) begin
        mode   = 1'($urandom);
        key_in = 3'($urandom);
        start  = ((cyc - t0) == 5) || ((cyc - t0) == total + 1);
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; key_in = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pat", pat, 0);
    chk("rst_key", key, 0); chk("rst_mcnt", mismatch_cnt, 0);
    chk("rst_found", key_found, 0); chk("rst_fkey", found_key, 0);

    // Pin the model with hand-derived numbers
    build_model(1'b0, 3'b111);
    chk("pin_verify_ok_mc", exp_mc, 0); chk("pin_verify_latency", total + 1, 65);
    build_model(1'b0, 3'b000);
    chk("pin_wrong_nonzero", exp_mc != 0, 1);
    build_model(1'b1, 3'b000);
    chk("pin_search_found", exp_found, 1); chk("pin_search_key", exp_fkey, 3'b111);
    unsolv = 1'b1;
    build_model(1'b1, 3'b000);
    chk("pin_unsolv_cycles", total, 16); chk("pin_unsolv_found", exp_found, 0);
    unsolv = 1'b0;

    run_sweep(1'b0, 3'b111, 1'b1);   // verify correct key, with ignored starts
    run_sweep(1'b0, 3'b000, 1'b0);   // verify wrong key
    run_sweep(1'b1, 3'b000, 1'b1);   // search, solution 3'b111
    unsolv = 1'b1;
    run_sweep(1'b1, 3'b000, 1'b0);   // search, unsolvable
    unsolv = 1'b0;

    // Reset in the middle of a verify sweep
    active = 1'b0;
    build_model(1'b0, 3'b010);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; key_in = 3'b010;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && pat != 5'd10; i++) @(negedge clk);
    chk("rst_wait_pat10", pat, 10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_pat", pat, 0); chk("mid_rst_key", key, 0);
    chk("mid_rst_mcnt", mismatch_cnt, 0); chk("mid_rst_found", key_found, 0);
    chk("mid_rst_fkey", found_key, 0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_done", done, 0);
      @(negedge clk);
    end
    run_sweep(1'b0, 3'b010, 1'b0);

    // Randomised locks, oracles, modes and keys
    for (int r = 0; r < 8; r++) begin
      tgt    = 3'($urandom);
      unsolv = ($urandom_range(0, 3) == 0);
      run_sweep(1'($urandom), 3'($urandom), 1'($urandom));
    end

    active = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
